// File: rtl/cam_sync_ctrl_pkg.sv
// Shared types and defaults for the structured-light camera/projector sync controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_sync_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_VS  = 3'd2,
    ST_WAIT_EXP = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_e;

  localparam int DEF_N_PHASE     = 4;
  localparam int DEF_N_FREQ      = 120;
  localparam int DEF_TIMEOUT_CYC = 2_000_000;

  // Projector vsyncs swallowed after start before the first capture.
  localparam int WARMUP_VS = 3;

endpackage

// File: rtl/cam_sync_ctrl_sync.sv
// 2-FF synchronizer followed by a registered rising-edge detect.
// Latency: 3 clocks from pin to one-cycle rise_o pulse.
// Backpressure: none; every synchronized rising edge yields exactly one pulse.
module sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q, rise_q;

  // Two-stage synchronizer, then compare with the delayed copy to find rising edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/cam_sync_ctrl.sv
// Sequences projector triggers and camera captures over N_PHASE x N_FREQ tagged frames.
// Latency: pin edge to FSM action is 4 clocks (3 in sync_edge, 1 registered FSM output).
// Backpressure: none; a vsync arriving while exposure is pending is dropped and flagged.
module cam_sync_ctrl
  import cam_sync_ctrl_pkg::*;
#(
  parameter int N_PHASE     = DEF_N_PHASE,
  parameter int N_FREQ      = DEF_N_FREQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       proj_vs,
  input  logic       proj_set,
  input  logic       exp_done,
  output logic       trig_out,
  output logic       frame_rdy,
  output logic       cap_strobe,
  output logic [1:0] phase_n,
  output logic [7:0] freq_k,
  output logic       busy,
  output logic       done,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       err_align
);

  localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]     PH_LAST   = 2'(N_PHASE - 1);
  localparam logic [7:0]     K_LAST    = 8'(N_FREQ);
  localparam logic [1:0]     WARM_LAST = 2'(WARMUP_VS - 1);

  logic vs_rise, set_rise, exp_rise;

  sync_edge u_sync_vs  (.clk_i(CLOCK_50), .rst_i(reset), .async_i(proj_vs),  .rise_o(vs_rise));
  sync_edge u_sync_set (.clk_i(CLOCK_50), .rst_i(reset), .async_i(proj_set), .rise_o(set_rise));
  sync_edge u_sync_exp (.clk_i(CLOCK_50), .rst_i(reset), .async_i(exp_done), .rise_o(exp_rise));

  state_e        state_q;
  logic [1:0]    warm_q;
  logic [TW-1:0] to_cnt_q;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    freq_q, freq_d;
  logic          trig_q, frame_q, cap_q, busy_q, done_q;
  logic          err_to_q, err_ov_q, err_al_q;
  logic          running, last_tag, timeout_hit;

  // Next frame tag: phase steps fastest, frequency advances on phase wrap.
  always_comb begin
    phase_d = phase_q + 2'd1;
    freq_d  = freq_q;
    if (phase_q == PH_LAST) begin
      phase_d = 2'd0;
      freq_d  = freq_q + 8'd1;
    end
  end

  assign running     = (state_q == ST_ARM) || (state_q == ST_WAIT_VS) || (state_q == ST_WAIT_EXP);
  assign last_tag    = (phase_q == PH_LAST) && (freq_q == K_LAST);
  assign timeout_hit = running && !vs_rise && (to_cnt_q == TO_LAST);

  // Capture sequencer with registered outputs; abort overrides everything but reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      warm_q   <= 2'd0;
      to_cnt_q <= '0;
      phase_q  <= 2'd0;
      freq_q   <= 8'd1;
      trig_q   <= 1'b0;
      frame_q  <= 1'b0;
      cap_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
      err_al_q <= 1'b0;
    end else if (abort) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      frame_q <= 1'b0;
      cap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cap_q  <= 1'b0;
      done_q <= 1'b0;
      if (running) to_cnt_q <= vs_rise ? '0 : to_cnt_q + TW'(1);
      // proj_set marks the first frame of a 4-frame group, which must be phase 1.
      if (running && set_rise && (phase_q != 2'd1)) err_al_q <= 1'b1;
      if (timeout_hit) begin
        state_q  <= ST_ERROR;
        err_to_q <= 1'b1;
        trig_q   <= 1'b0;
        frame_q  <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_ERROR: begin
            if (start) begin
              state_q  <= ST_ARM;
              warm_q   <= 2'd0;
              to_cnt_q <= '0;
              phase_q  <= 2'd0;
              freq_q   <= 8'd1;
              trig_q   <= 1'b1;
              frame_q  <= 1'b1;
              busy_q   <= 1'b1;
              err_to_q <= 1'b0;
              err_ov_q <= 1'b0;
              err_al_q <= 1'b0;
            end
          end
          ST_ARM: begin
            if (vs_rise) begin
              warm_q <= warm_q + 2'd1;
              if (warm_q == WARM_LAST) state_q <= ST_WAIT_VS;
            end
          end
          ST_WAIT_VS: begin
            if (vs_rise) begin
              cap_q   <= 1'b1;
              frame_q <= 1'b0;
              state_q <= ST_WAIT_EXP;
            end
          end
          ST_WAIT_EXP: begin
            if (exp_rise) begin
              phase_q <= phase_d;
              freq_q  <= freq_d;
              if (last_tag) begin
                state_q <= ST_DONE;
                trig_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (vs_rise) begin
                // Same-cycle vsync starts the next frame with the advanced tag.
                cap_q <= 1'b1;
              end else begin
                state_q <= ST_WAIT_VS;
                frame_q <= 1'b1;
              end
            end else if (vs_rise) begin
              err_ov_q <= 1'b1;
            end
          end
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign trig_out    = trig_q;
  assign frame_rdy   = frame_q;
  assign cap_strobe  = cap_q;
  assign phase_n     = phase_q;
  assign freq_k      = freq_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;
  assign err_align   = err_al_q;

endmodule

// File: tb/tb_cam_sync_ctrl.sv
// Directed bench for cam_sync_ctrl with N_PHASE=4, N_FREQ=2, TIMEOUT_CYC=1000.
// Latency: inputs driven 1 ns after posedge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_cam_sync_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       reset, start, abort, proj_vs, proj_set, exp_done;
  logic       trig_out, frame_rdy, cap_strobe, busy, done;
  logic       err_timeout, err_overrun, err_align;
  logic [1:0] phase_n;
  logic [7:0] freq_k;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [9:0] strobe_tags[$];

  cam_sync_ctrl #(.N_PHASE(4), .N_FREQ(2), .TIMEOUT_CYC(1000)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .abort(abort),
    .proj_vs(proj_vs), .proj_set(proj_set), .exp_done(exp_done),
    .trig_out(trig_out), .frame_rdy(frame_rdy), .cap_strobe(cap_strobe),
    .phase_n(phase_n), .freq_k(freq_k), .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_align(err_align)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Record every cap_strobe tag {phase,freq} and count done pulses.
  always @(negedge CLOCK_50) begin
    if (cap_strobe) strobe_tags.push_back({phase_n, freq_k});
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_vs();
    proj_vs = 1'b1; tick(4); proj_vs = 1'b0; tick(4);
  endtask

  task automatic pulse_exp();
    exp_done = 1'b1; tick(4); exp_done = 1'b0; tick(4);
  endtask

  task automatic pulse_set();
    proj_set = 1'b1; tick(4); proj_set = 1'b0; tick(4);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic warmup();
    repeat (3) pulse_vs();
  endtask

  initial begin
    int base;
    int waited;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    proj_vs = 1'b0; proj_set = 1'b0; exp_done = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    check("rst_trig",  trig_out,  0);
    check("rst_frame", frame_rdy, 0);
    check("rst_busy",  busy,      0);
    check("rst_freq",  freq_k,    1);
    check("rst_phase", phase_n,   0);
    check("rst_errs",  {err_timeout, err_overrun, err_align}, 0);

    // Normal run: 3 warm-up vsyncs, then 8 tagged frames
    pulse_start();
    check("arm_busy", busy, 1);
    check("arm_trig", trig_out, 1);
    warmup();
    check("warm_no_strobe", strobe_tags.size(), 0);
    check("warm_frame_rdy", frame_rdy, 1);
    for (int i = 0; i < 8; i++) begin
      pulse_vs();
      pulse_exp();
    end
    check("run_strobes", strobe_tags.size(), 8);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] ep;
      logic [7:0] ek;
      ep = 2'(i % 4);
      ek = 8'(i / 4 + 1);
      if (i < strobe_tags.size()) check($sformatf("run_tag%0d", i), strobe_tags[i], {ep, ek});
    end
    check("run_done_cnt", done_cnt, 1);
    check("run_trig_low", trig_out, 0);
    check("run_busy_low", busy, 0);

    // Overrun: second vsync before exp_done
    base = strobe_tags.size();
    pulse_start();
    warmup();
    pulse_vs();
    check("ov_first_strobe", strobe_tags.size(), base + 1);
    pulse_vs();
    check("ov_flag", err_overrun, 1);
    check("ov_no_strobe", strobe_tags.size(), base + 1);
    check("ov_tag_held", {phase_n, freq_k}, {2'd0, 8'd1});
    pulse_exp();
    check("ov_phase_adv", phase_n, 1);

    // Alignment: proj_set at phase 1 is fine, at phase 3 is an error
    pulse_set();
    check("align_ok", err_align, 0);
    repeat (2) begin
      pulse_vs();
      pulse_exp();
    end
    check("align_phase3", phase_n, 3);
    pulse_set();
    check("align_err", err_align, 1);

    // Simultaneous vsync and exp_done in WAIT_EXP
    pulse_vs();
    base = strobe_tags.size();
    proj_vs = 1'b1; exp_done = 1'b1; tick(4);
    proj_vs = 1'b0; exp_done = 1'b0; tick(4);
    check("sim_strobe_cnt", strobe_tags.size(), base + 1);
    if (strobe_tags.size() > 0) check("sim_strobe_tag", strobe_tags[$], {2'd0, 8'd2});
    check("sim_busy", busy, 1);

    // Abort and start together in WAIT_EXP
    abort = 1'b1; start = 1'b1; tick(1);
    abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_trig", trig_out, 0);
    check("abort_done", done_cnt, 1);

    // Timeout: vsync stops in WAIT_VS
    pulse_start();
    check("to_errs_cleared", {err_timeout, err_overrun, err_align}, 0);
    warmup();
    waited = 0;
    while (busy && waited < 1100) begin
      tick(1);
      waited++;
    end
    check("to_reached", busy, 0);
    check("to_window", (waited >= 990 && waited <= 1000), 1);
    check("to_flag", err_timeout, 1);
    check("to_trig", trig_out, 0);
    pulse_start();
    check("to_restart_busy", busy, 1);
    check("to_restart_clear", err_timeout, 0);
    check("to_restart_trig", trig_out, 1);

    // Reset mid-capture
    warmup();
    pulse_vs();
    reset = 1'b1; tick(1);
    check("rst_mid_trig", trig_out, 0);
    reset = 1'b0; tick(3);
    check("rst_mid_done", done_cnt, 1);
    check("rst_mid_freq", freq_k, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
